cpu_core_mc: RTL
================

# cpu_core_mc

Multi-cycle RV32I integer core, successor to the single-cycle core. Executes each instruction through a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine. Talks to instruction and data memories over request/ready handshakes, so wait-state memories are supported. The memory address width and reset vector are parametrised. Sits between the instruction ROM and the data RAM/peripheral bus. The internal 32x32 register file has x0 hardwired to zero.

## Interface
- ADDR_W, 10, word-address width of both memory ports (byte space = 2^(ADDR_W+2))
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- CLK  in  1  core clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch word address = PC[ADDR_W+1:2]
- imem_rdata  in  32  instruction word; valid when imem_ready=1
- imem_ready  in  1  fetch completes in any cycle where imem_req=1 and imem_ready=1
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; qualified by dmem_req
- dmem_addr  out  ADDR_W  data word address = ALU_result[ADDR_W+1:2]
- dmem_wdata  out  32  store data (rs2)
- dmem_rdata  in  32  load data; valid when dmem_ready=1
- dmem_ready  in  1  access completes in any cycle where dmem_req=1 and dmem_ready=1
- retire  out  1  one-cycle pulse when an instruction completes
- pc_o  out  32  current PC, for debug and the bench
- trap  out  1  sticky illegal-instruction flag; present only with CPU_MC_TRAP_EN, tied 0 otherwise

## Operation
- Supported: R-type ALU (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND), I-type ALU (incl. SLLI SRLI SRAI), LW, SW, BEQ BNE BLT BGE BLTU BGEU, LUI, AUIPC, JAL, JALR. All memory accesses are word accesses.
- Reset (RST=1, async): state=FETCH; PC=RESET_PC; all registers=0; IR=0.
- Reset output values: imem_req=0, dmem_req=0, dmem_we=0, retire=0, trap=0, pc_o=RESET_PC.
- Address outputs while in reset: imem_addr=RESET_PC[ADDR_W+1:2]; dmem_addr and dmem_wdata=0.
- FETCH: imem_req=1. On imem_ready, latch IR<=imem_rdata and go to DECODE.
- DECODE: read rs1/rs2 into A/B and build the immediate. All ALU/branch/jump instructions go to EXECUTE.
- EXECUTE: compute ALU_result and the branch/jump target.
  - LW/SW go to MEMORY.
  - All other instructions go to WRITEBACK.
- MEMORY: dmem_req=1, with dmem_we=1 for SW. Address and wdata are held stable until ready. On dmem_ready: LW latches MDR and goes to WRITEBACK; SW goes to WRITEBACK.
- WRITEBACK: write rd when rd≠0 and the instruction writes (ALU, LW, LUI, AUIPC, JAL/JALR writes PC+4), then update PC, pulse retire, go to FETCH.
- PC update rules:
  - taken branch: PC+imm_B
  - JAL: PC+imm_J
  - JALR: (rs1+imm_I)&~1
  - everything else: PC+4
- Arithmetic is 32-bit modulo 2^32. Shift amount = low 5 bits. SLT is signed, SLTU unsigned.
- Misaligned addresses: the low 2 bits of data and jump addresses are dropped on the memory ports; no exception is raised.
- A PC beyond the ADDR_W range wraps through imem_addr truncation.
- JALR with rd=rs1 uses the pre-write rs1 value.

## Timing
- Zero-wait latencies in cycles: ALU/LUI/AUIPC/branch/jump take 4 (F,D,E,W); LW and SW take 5 (F,D,E,M,W).
- Each cycle with ready=0 while req=1 adds one cycle. Request signals stay asserted and their address/data stay constant until ready.
- Ready while req=0 is ignored.
- req is never asserted on both ports in the same cycle.
- retire is high exactly during the WRITEBACK cycle. The register write and the PC update take effect at the end of that cycle.
- RST asserted mid-access drops req in the same cycle (async); no write is committed for the aborted instruction.
- After RST deasserts, the first imem_req=1 occurs in the first cycle.

## Configuration
- CPU_MC_TRAP_EN defined: an unsupported opcode or funct combination detected in DECODE enters the TRAP state.
  - TRAP: trap=1; no register, memory or PC change; no further requests; retire stays 0. Only RST exits TRAP.
- CPU_MC_TRAP_EN undefined: unsupported encodings execute as NOP (PC+4, retire pulses, no writes), and trap is tied 0.

## Test plan
- Reset with RESET_PC=32'h40 and zero-wait memories: first imem_addr=16. ADDI x1,x0,5 then ADD x2,x1,x1 leaves x2=10, with retire every 4 cycles.
- Wait states: SW x2,8(x0), then LW x3,8(x0), with dmem_ready low for 3 cycles each. Required: dmem_req/addr=2/wdata=10 held stable throughout, x3=10, each instruction retires after 8 cycles.
- BNE x1,x0,-8 with x1=5: PC goes back by 8. BEQ x1,x0,-8 with x1=5: PC+4. Each retires in 4 cycles.
- JAL x1,+16 at PC=0x100: x1=0x104, PC=0x110. JALR x0,3(x1): PC=0x106 (bit 0 cleared).
- SUB x5,x0,1 then SRA x6,x5,31: x6=0xFFFF_FFFF. SRL on the same operands gives 1. ADDI x0,x0,7 leaves x0 reading 0.
- Opcode 7'h7F: with CPU_MC_TRAP_EN, trap=1 and no further imem_req. Without it, PC+4 and retire pulses. RST raised during MEMORY drops dmem_req the same cycle and the store is not committed.

Source files
------------

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle RV32I core with request/ready memory ports; optional illegal-opcode trap under CPU_MC_TRAP_EN
module cpu_core_mc #(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RST,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ready,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ready,
   output logic              retire,
   output logic [31:0]       pc_o,
   output logic              trap
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q, npc_q;
   logic [31:0] rf_q [32];
   logic [31:0] imm_d, alu_d, npc_d, wb_d, op_a, op_b, sra_r;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic        lg, o_r, o_i, o_lw, o_sw, o_br, o_lui, o_aui, o_jal, o_jalr, take, wr;

   assign opc = ir_q[6:0];
   assign rd  = ir_q[11:7];
   assign f3  = ir_q[14:12];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign f7  = ir_q[31:25];

   // legality of the latched encoding; illegal words disable every operation flag below
   always_comb begin
      lg = 1'b0;
      case (opc)
         7'b0110011: lg = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
         7'b0010011: lg = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
         7'b0000011, 7'b0100011: lg = f3 == 3'b010;
         7'b1100011: lg = f3 != 3'b010 && f3 != 3'b011;
         7'b1100111: lg = f3 == 3'b000;
         7'b0110111, 7'b0010111, 7'b1101111: lg = 1'b1;
         default: lg = 1'b0;
      endcase
   end

   assign o_r    = lg && opc == 7'b0110011;
   assign o_i    = lg && opc == 7'b0010011;
   assign o_lw   = lg && opc == 7'b0000011;
   assign o_sw   = lg && opc == 7'b0100011;
   assign o_br   = lg && opc == 7'b1100011;
   assign o_lui  = lg && opc == 7'b0110111;
   assign o_aui  = lg && opc == 7'b0010111;
   assign o_jal  = lg && opc == 7'b1101111;
   assign o_jalr = lg && opc == 7'b1100111;
   assign wr     = (o_r | o_i | o_lw | o_lui | o_aui | o_jal | o_jalr) && rd != 5'd0;

   assign imm_d = o_sw ? {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]}
                : o_br ? {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}
                : (o_lui | o_aui) ? {ir_q[31:12], 12'b0}
                : o_jal ? {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}
                : {{20{ir_q[31]}}, ir_q[31:20]};

   assign op_a  = o_aui ? pc_q : a_q;
   assign op_b  = o_r ? b_q : imm_q;
   assign sra_r = $signed(op_a) >>> op_b[4:0];

   // ALU: loads, stores, JALR and AUIPC use the adder; LUI passes the immediate
   always_comb begin
      alu_d = op_a + op_b;
      if (o_lui) alu_d = imm_q;
      else if (o_r | o_i)
         case (f3)
            3'b000: alu_d = (o_r && f7[5]) ? op_a - op_b : op_a + op_b;
            3'b001: alu_d = op_a << op_b[4:0];
            3'b010: alu_d = {31'b0, $signed(op_a) < $signed(op_b)};
            3'b011: alu_d = {31'b0, op_a < op_b};
            3'b100: alu_d = op_a ^ op_b;
            3'b101: alu_d = f7[5] ? sra_r : op_a >> op_b[4:0];
            3'b110: alu_d = op_a | op_b;
            default: alu_d = op_a & op_b;
         endcase
   end

   assign take  = o_br && (f3[2:1] == 2'b00 ? (a_q == b_q) ^ f3[0]
                         : f3[2:1] == 2'b10 ? ($signed(a_q) < $signed(b_q)) ^ f3[0]
                         : (a_q < b_q) ^ f3[0]);
   assign npc_d = (o_jal || take) ? pc_q + imm_q : o_jalr ? (a_q + imm_q) & ~32'd1 : pc_q + 32'd4;
   assign wb_d  = o_lw ? mdr_q : (o_jal | o_jalr) ? pc_q + 32'd4 : alu_q;

   // sequencing and handshake outputs; reset kills requests combinationally
   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) state_d = S_DECODE;
         end
`ifdef CPU_MC_TRAP_EN
         S_DECODE: state_d = lg ? S_EXEC : S_TRAP;
`else
         S_DECODE: state_d = S_EXEC;
`endif
         S_EXEC: state_d = (o_lw | o_sw) ? S_MEM : S_WB;
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = o_sw;
            if (dmem_ready) state_d = S_WB;
         end
         S_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = state_q;
      endcase
      if (RST) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
      end
   end

   // state, PC and the per-stage holding registers
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         npc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_FETCH && imem_ready) ir_q <= imem_rdata;
         if (state_q == S_DECODE) begin
            a_q   <= rf_q[rs1];
            b_q   <= rf_q[rs2];
            imm_q <= imm_d;
         end
         if (state_q == S_EXEC) begin
            alu_q <= alu_d;
            npc_q <= npc_d;
         end
         if (state_q == S_MEM && dmem_ready && o_lw) mdr_q <= dmem_rdata;
         if (state_q == S_WB) pc_q <= npc_q;
      end

   // register file written only in WRITEBACK; x0 is never written so it always reads zero
   always_ff @(posedge CLK or posedge RST)
      if (RST) for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      else if (state_q == S_WB && wr) rf_q[rd] <= wb_d;

   assign imem_addr  = pc_q[ADDR_W+1:2];
   assign dmem_addr  = alu_q[ADDR_W+1:2];
   assign dmem_wdata = b_q;
   assign pc_o       = pc_q;
`ifdef CPU_MC_TRAP_EN
   assign trap = state_q == S_TRAP;
`else
   assign trap = 1'b0;
`endif
endmodule
